i2c_poll_scheduler: RTL and testbench

//  Sequencer for the i2c_poll MPU9250 reader. Steps register_address through a fixed

---
 rtl/i2c_poll_pkg.sv | 22 ++
 rtl/poll_state_sync.sv | 38 +++
 rtl/i2c_poll_scheduler.sv | 143 ++++++++++++++
 tb/tb_i2c_poll_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_poll_pkg.sv
// Shared encodings for the i2c_poll sequencer: poller state codes and scheduler FSM states.
package i2c_poll_pkg;

   localparam logic [4:0] PS_IDLE      = 5'd0;
   localparam logic [4:0] PS_ACKNACK1C = 5'd8;
   localparam logic [4:0] PS_ACKNACK2C = 5'd13;
   localparam logic [4:0] PS_ACKNACK3C = 5'd23;
   localparam logic [4:0] PS_NACK      = 5'd30;
   localparam logic [4:0] PS_STOP1A    = 5'd31;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_RECOVER  = 2'd3
   } sched_state_e;

   function automatic logic is_ack_check(input logic [4:0] s);
      return (s == PS_ACKNACK1C) || (s == PS_ACKNACK2C) || (s == PS_ACKNACK3C);
   endfunction

endpackage

// File: rtl/poll_state_sync.sv
// Brings the slow-domain poller state across with two flops, then only accepts a
// value once two consecutive synchronized samples agree.
module poll_state_sync (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_state,
   output logic [4:0] o_prev,
   output logic [4:0] o_cur,
   output logic       o_evt
);

   logic [4:0] r_meta;
   logic [4:0] r_sync;
   logic [4:0] r_sync_d;
   logic [4:0] r_stable;
   logic       w_agree;

   assign w_agree = (r_sync == r_sync_d);
   // Event is visible the cycle the new value is accepted, saving a cycle of latency.
   assign o_evt   = w_agree && (r_sync != r_stable);
   assign o_prev  = r_stable;
   assign o_cur   = r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= '0;
         r_sync   <= '0;
         r_sync_d <= '0;
         r_stable <= '0;
      end else begin
         r_meta   <= i_state;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         if (w_agree) r_stable <= r_sync;
      end
   end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Round-robin register sequencer for the i2c_poll reader: captures readings per
// channel and recovers the poller from NACKs and hangs.
//
//  state    | meaning
//  DISABLED | poller held in reset, waiting for enable
//  RUN      | transaction in flight, watchdog counting down
//  CAPTURE  | store reading, advance channel and register address
//  RECOVER  | poller held in reset for RECOVER_CYCLES after a hang
module i2c_poll_scheduler
   import i2c_poll_pkg::*;
#(
   parameter int                        NUM_CHANNELS   = 4,
   parameter logic [6:0]                DEVICE_ADDR    = 7'h68,
   parameter logic [8*NUM_CHANNELS-1:0] REG_LIST       = {8'h47, 8'h43, 8'h3F, 8'h3B},
   parameter int                        TIMEOUT_CYCLES = 100000,
   parameter int                        RECOVER_CYCLES = 256
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_enable,
   input  logic [4:0]                   i_poll_state,
   input  logic [15:0]                  i_poll_reading,
   output logic                         o_poll_reset,
   output logic [7:0]                   o_register_address,
   output logic [6:0]                   o_device_address,
   output logic [16*NUM_CHANNELS-1:0]   o_data_out,
   output logic                         o_sample_valid,
   output logic [3:0]                   o_sample_index,
   output logic                         o_ack_error,
   output logic                         o_timeout,
   output logic [7:0]                   o_error_count
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

   sched_state_e               r_state, w_next;
   logic [WD_W-1:0]            r_wdog;
   logic [RC_W-1:0]            r_rec;
   logic [3:0]                 r_channel, w_ch_next;
   logic [7:0]                 r_reg_addr;
   logic [16*NUM_CHANNELS-1:0] r_data;
   logic                       r_sample_valid, r_ack_error, r_timeout, r_poll_reset;
   logic [3:0]                 r_sample_index;
   logic [7:0]                 r_err;
   logic [4:0]                 w_prev, w_cur;
   logic                       w_evt, w_done, w_afail;
   logic                       w_capture, w_ack, w_to;

   poll_state_sync u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_state (i_poll_state),
      .o_prev  (w_prev),
      .o_cur   (w_cur),
      .o_evt   (w_evt)
   );

   assign w_done    = w_evt && (w_prev == PS_NACK) && (w_cur == PS_STOP1A);
   assign w_afail   = w_evt && is_ack_check(w_prev) && (w_cur == PS_IDLE);
   assign w_ch_next = (r_channel == 4'(NUM_CHANNELS - 1)) ? 4'd0 : r_channel + 4'd1;

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_ack     = 1'b0;
      w_to      = 1'b0;
      case (r_state)
         ST_DISABLED: if (i_enable) w_next = ST_RUN;
         ST_RUN: begin
            if (w_done) begin
               w_next = ST_CAPTURE;
            end else if (w_afail) begin
               w_ack = 1'b1;
            end else if (r_wdog == '0) begin
               w_to   = 1'b1;
               w_next = ST_RECOVER;
            end
         end
         ST_CAPTURE: begin
            w_capture = 1'b1;
            w_next    = ST_RUN;
         end
         ST_RECOVER: if (r_rec == '0) w_next = ST_RUN;
         default:    w_next = ST_DISABLED;
      endcase
      // Dropping enable aborts everything, including a pending capture.
      if (!i_enable) begin
         w_next    = ST_DISABLED;
         w_capture = 1'b0;
         w_ack     = 1'b0;
         w_to      = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= ST_DISABLED;
         r_wdog         <= WD_W'(TIMEOUT_CYCLES - 1);
         r_rec          <= RC_W'(RECOVER_CYCLES - 1);
         r_channel      <= '0;
         r_reg_addr     <= REG_LIST[7:0];
         r_data         <= '0;
         r_sample_valid <= 1'b0;
         r_sample_index <= '0;
         r_ack_error    <= 1'b0;
         r_timeout      <= 1'b0;
         r_err          <= '0;
         r_poll_reset   <= 1'b1;
      end else begin
         r_state        <= w_next;
         r_poll_reset   <= (w_next == ST_DISABLED) || (w_next == ST_RECOVER);
         r_sample_valid <= w_capture;
         r_ack_error    <= w_ack;
         r_timeout      <= w_to;
         // Watchdog down-counter restarts on every RUN entry and on each NACK retry.
         if (r_state != ST_RUN || w_ack) r_wdog <= WD_W'(TIMEOUT_CYCLES - 1);
         else                             r_wdog <= r_wdog - 1'b1;
         if (r_state != ST_RECOVER) r_rec <= RC_W'(RECOVER_CYCLES - 1);
         else                       r_rec <= r_rec - 1'b1;
         if (w_capture) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
               if (r_channel == 4'(k)) r_data[16*k +: 16] <= i_poll_reading;
            end
            r_sample_index <= r_channel;
            r_channel      <= w_ch_next;
            r_reg_addr     <= REG_LIST[8*w_ch_next +: 8];
         end
         if ((w_ack || w_to) && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      end
   end

   assign o_poll_reset       = r_poll_reset;
   assign o_register_address = r_reg_addr;
   assign o_device_address   = DEVICE_ADDR;
   assign o_data_out         = r_data;
   assign o_sample_valid     = r_sample_valid;
   assign o_sample_index     = r_sample_index;
   assign o_ack_error        = r_ack_error;
   assign o_timeout          = r_timeout;
   assign o_error_count      = r_err;

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Bench for i2c_poll_scheduler: drives poller state codes directly and checks
// captures, NACK handling, watchdog recovery, enable abort and reset.
module tb_i2c_poll_scheduler;

   localparam int T_CYC = 300;
   localparam int R_CYC = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [4:0]  ps = 5'd0;
   logic [15:0] rd = 16'h0;
   logic        poll_reset, sample_valid, ack_error, timeout_p;
   logic [7:0]  reg_addr, err_count;
   logic [6:0]  dev_addr;
   logic [63:0] data_out;
   logic [3:0]  sample_index;

   int n_total = 0;
   int n_pass  = 0;
   int cnt_ack = 0;
   int cnt_to  = 0;
   int cnt_sv  = 0;

   // reference model
   int          m_ch = 0;
   int          m_err = 0;
   logic [15:0] m_bank [4];
   logic [7:0]  m_regs [4];

   typedef struct {
      int          kind;     // 0 = completed read, 1 = NACK
      logic [15:0] rdv;
      int          exp_idx;
      logic [7:0]  exp_addr;
      int          exp_err;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   i2c_poll_scheduler #(
      .TIMEOUT_CYCLES (T_CYC),
      .RECOVER_CYCLES (R_CYC)
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_enable           (enable),
      .i_poll_state       (ps),
      .i_poll_reading     (rd),
      .o_poll_reset       (poll_reset),
      .o_register_address (reg_addr),
      .o_device_address   (dev_addr),
      .o_data_out         (data_out),
      .o_sample_valid     (sample_valid),
      .o_sample_index     (sample_index),
      .o_ack_error        (ack_error),
      .o_timeout          (timeout_p),
      .o_error_count      (err_count)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (ack_error)    cnt_ack++;
         if (timeout_p)    cnt_to++;
         if (sample_valid) cnt_sv++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_le(input string name, input int act, input int lim);
      n_total++;
      if (act <= lim) n_pass++;
      else $display("FAIL %s: got %0d required <= %0d", name, act, lim);
   endtask

   task automatic hold(input logic [4:0] s, input int n);
      ps = s;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [63:0] model_bank();
      return {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
   endfunction

   // Full read transaction; returns captured index (-1 if none) and latency from STOP1A.
   task automatic do_done(input logic [15:0] v, output int got_idx, output int lat);
      got_idx = -1;
      lat     = 99;
      hold(5'd0, 4); hold(5'd5, 4); hold(5'd30, 4);
      rd = v;
      ps = 5'd31;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (sample_valid) begin
            got_idx = int'(sample_index);
            lat     = k;
            break;
         end
      end
      if (got_idx >= 0) begin
         m_bank[m_ch] = v;
         m_ch = (m_ch + 1) % 4;
      end
      hold(5'd31, 2);
      hold(5'd0, 2);
   endtask

   task automatic do_afail();
      hold(5'd0, 4); hold(5'd8, 4); hold(5'd0, 6);
      if (m_err < 255) m_err++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_bank"}, data_out, model_bank());
      chk({tag, "_addr"}, 64'(reg_addr), 64'(m_regs[m_ch]));
      chk({tag, "_err"}, 64'(err_count), 64'(m_err));
   endtask

   initial begin
      int gi, lat, b, n, c, exp_i, op;
      m_regs[0] = 8'h3B; m_regs[1] = 8'h3F; m_regs[2] = 8'h43; m_regs[3] = 8'h47;
      for (int i = 0; i < 4; i++) m_bank[i] = 16'h0;
      tbl[0] = '{0, 16'h1234, 0, 8'h3F, 0};
      tbl[1] = '{0, 16'h5678, 1, 8'h43, 0};
      tbl[2] = '{1, 16'h0000, -1, 8'h43, 1};
      tbl[3] = '{0, 16'h9ABC, 2, 8'h47, 1};
      tbl[4] = '{0, 16'hDEF0, 3, 8'h3B, 1};
      tbl[5] = '{0, 16'h1111, 0, 8'h3F, 1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_poll_reset", 64'(poll_reset), 64'd1);
      chk("rst_data", data_out, 64'd0);
      chk("rst_addr", 64'(reg_addr), 64'h3B);
      chk("rst_dev", 64'(dev_addr), 64'h68);
      chk("rst_err", 64'(err_count), 64'd0);
      chk("rst_sv", {sample_valid, sample_index}, 64'd0);
      rst_n = 1'b1;
      hold(5'd0, 3);
      chk("disabled_poll_reset", 64'(poll_reset), 64'd1);
      enable = 1'b1;
      @(posedge clk); #1;
      chk("enable_poll_reset", 64'(poll_reset), 64'd0);

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].kind == 0) begin
            do_done(tbl[i].rdv, gi, lat);
            chk("tbl_idx", 64'(gi), 64'(tbl[i].exp_idx));
            chk_le("tbl_latency", lat, 5);
         end else begin
            b = cnt_ack;
            do_afail();
            chk("tbl_ack_pulse", 64'(cnt_ack - b), 64'd1);
         end
         chk("tbl_addr", 64'(reg_addr), 64'(tbl[i].exp_addr));
         chk("tbl_err", 64'(err_count), 64'(tbl[i].exp_err));
      end
      check_model("tbl");

      // watchdog: stall after a capture, expect timeout exactly T_CYC cycles later
      hold(5'd0, 4); hold(5'd5, 4); hold(5'd30, 4);
      rd = 16'hA5A5;
      ps = 5'd31;
      gi = -1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (sample_valid) begin gi = 1; break; end
      end
      chk("to_pre_capture", 64'(gi), 64'd1);
      m_bank[m_ch] = 16'hA5A5;
      m_ch = (m_ch + 1) % 4;
      ps = 5'd5;
      n = 0;
      for (int k = 1; k <= T_CYC + 50; k++) begin
         @(posedge clk); #1;
         if (timeout_p) begin n = k; break; end
      end
      chk("timeout_cycles", 64'(n), 64'(T_CYC));
      if (m_err < 255) m_err++;
      c = 0;
      for (int k = 0; k < R_CYC + 20 && poll_reset; k++) begin
         c++;
         @(posedge clk); #1;
      end
      chk("recover_width", 64'(c), 64'(R_CYC));
      chk("timeout_count", 64'(cnt_to), 64'd1);
      check_model("to");
      exp_i = m_ch;
      do_done(16'h7E57, gi, lat);
      chk("to_same_channel", 64'(gi), 64'(exp_i));

      // enable drop mid-read of channel 2
      while (m_ch != 2) do_done(16'($urandom), gi, lat);
      hold(5'd0, 4); hold(5'd5, 4);
      enable = 1'b0;
      @(posedge clk); #1;
      chk("abort_poll_reset", 64'(poll_reset), 64'd1);
      b = cnt_sv;
      hold(5'd30, 4); rd = 16'hBEEF; hold(5'd31, 6); hold(5'd0, 4);
      chk("abort_no_sample", 64'(cnt_sv - b), 64'd0);
      check_model("abort");
      enable = 1'b1;
      @(posedge clk); #1;
      chk("reenable_poll_reset", 64'(poll_reset), 64'd0);
      do_done(16'hC0DE, gi, lat);
      chk("reenable_idx", 64'(gi), 64'd2);
      check_model("reenable");

      // randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            exp_i = m_ch;
            do_done(16'($urandom), gi, lat);
            chk("rnd_idx", 64'(gi), 64'(exp_i));
            chk_le("rnd_latency", lat, 5);
         end else if (op == 1) begin
            b = cnt_ack;
            do_afail();
            chk("rnd_ack", 64'(cnt_ack - b), 64'd1);
         end else begin
            b = cnt_sv;
            hold(5'd0, 4); hold(5'd5, 3);
            enable = 1'b0;
            hold(5'd30, 4); rd = 16'($urandom); hold(5'd31, 5); hold(5'd0, 4);
            enable = 1'b1;
            hold(5'd0, 2);
            chk("rnd_abort", 64'(cnt_sv - b), 64'd0);
         end
         check_model("rnd");
      end

      // saturation
      b = cnt_ack;
      for (int i = 0; i < 300; i++) do_afail();
      chk("sat_ack_pulses", 64'(cnt_ack - b), 64'd300);
      chk("sat_err", 64'(err_count), 64'hFF);
      check_model("sat");

      // asynchronous reset mid-transaction
      hold(5'd0, 4); hold(5'd5, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_poll_reset", 64'(poll_reset), 64'd1);
      chk("arst_data", data_out, 64'd0);
      chk("arst_err", 64'(err_count), 64'd0);
      chk("arst_addr", 64'(reg_addr), 64'h3B);
      chk("arst_sample", {sample_valid, sample_index, ack_error, timeout_p}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
